// File: rtl/muldiv_pkg.sv
// Shared constants, FSM state type and arithmetic helpers for the RV32M
// multiply/divide unit.
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [5:0] ITER_CNT = 6'd32;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return 32'd0 - v;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] v);
    return 64'd0 - v;
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Shared 64-bit accumulator for shift-add multiply and restoring divide.
// The upper half holds the partial product / remainder, the lower half the
// multiplier / dividend-being-shifted-into-quotient.
module muldiv_iter_core
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        step,
  input  logic        mode_div,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic [63:0] acc_next
);

  logic [63:0] acc_r;
  logic [31:0] opb_r;
  logic [32:0] add_s;
  logic        ge_s;
  logic [31:0] sub_s;
  logic [31:0] div_hi_s;

  // One iteration of either algorithm, chosen by mode_div
  always_comb begin
    add_s    = {1'b0, acc_r[63:32]} + (acc_r[0] ? {1'b0, opb_r} : 33'd0);
    // Shifted partial remainder is 33 bits wide; the subtraction fits in 32
    // whenever it is taken because the result is below the divisor.
    ge_s     = (acc_r[63:31] >= {1'b0, opb_r});
    sub_s    = acc_r[62:31] - opb_r;
    div_hi_s = ge_s ? sub_s : acc_r[62:31];
    if (mode_div) begin
      acc_next = {div_hi_s, acc_r[30:0], ge_s};
    end else begin
      acc_next = {add_s, acc_r[31:1]};
    end
  end

  // Accumulator and second-operand registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_r <= 64'd0;
      opb_r <= 32'd0;
    end else if (load) begin
      acc_r <= {32'd0, op_a};
      opb_r <= op_b;
    end else if (step) begin
      acc_r <= acc_next;
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage RV32M multiply/divide unit: FSM, sign handling, special cases and
// output registers. Define MULDIV_FAST_MUL_EN for single-cycle multiplies.
module ex_muldiv
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd_addr,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  state_t      state_r, state_nxt_s;
  logic [5:0]  cnt_r, cnt_nxt_s;
  logic [2:0]  funct3_r;
  logic [4:0]  rd_r;
  logic        neg_a_r, neg_b_r;
  logic [31:0] result_r;
  logic [4:0]  rd_out_r;
  logic        done_r;

  logic        sgn_a_s, sgn_b_s, neg_a_s, neg_b_s;
  logic [31:0] mag_a_s, mag_b_s;
  logic        div_zero_s, div_ovf_s, fast_s, special_s;
  logic [31:0] special_res_s, final_res_s;
  logic [63:0] acc_next_s, prod_s;
  logic [31:0] quo_s, rem_s;
  logic        load_s, step_s, fin_s, spec_s;

  // Operand signedness per funct3
  always_comb begin
    case (funct3)
      F3_MULH, F3_DIV, F3_REM: begin sgn_a_s = 1'b1; sgn_b_s = 1'b1; end
      F3_MULHSU:               begin sgn_a_s = 1'b1; sgn_b_s = 1'b0; end
      default:                 begin sgn_a_s = 1'b0; sgn_b_s = 1'b0; end
    endcase
  end

  assign neg_a_s = sgn_a_s & rs1_val[31];
  assign neg_b_s = sgn_b_s & rs2_val[31];
  assign mag_a_s = neg_a_s ? neg32(rs1_val) : rs1_val;
  assign mag_b_s = neg_b_s ? neg32(rs2_val) : rs2_val;

  assign div_zero_s = funct3[2] & (rs2_val == 32'd0);
  assign div_ovf_s  = funct3[2] & ~funct3[0] & (rs1_val == 32'h8000_0000) &
                      (rs2_val == 32'hFFFF_FFFF);

`ifdef MULDIV_FAST_MUL_EN
  logic [63:0] fast_a_s, fast_b_s, fast_prod_s;
  // 64-bit sign extension keeps the low 64 product bits of the 33x33 multiply
  assign fast_a_s    = {{32{neg_a_s}}, rs1_val};
  assign fast_b_s    = {{32{neg_b_s}}, rs2_val};
  assign fast_prod_s = fast_a_s * fast_b_s;
  assign fast_s      = ~funct3[2];
`else
  assign fast_s      = 1'b0;
`endif

  assign special_s = div_zero_s | div_ovf_s | fast_s;

  // Result for paths that skip the iterative datapath
  always_comb begin
    special_res_s = 32'd0;
    if (div_ovf_s) begin
      special_res_s = funct3[1] ? 32'd0 : 32'h8000_0000;
    end else if (div_zero_s) begin
      special_res_s = funct3[1] ? rs1_val : 32'hFFFF_FFFF;
    end else begin
`ifdef MULDIV_FAST_MUL_EN
      special_res_s = (funct3 == F3_MUL) ? fast_prod_s[31:0] : fast_prod_s[63:32];
`else
      special_res_s = 32'd0;
`endif
    end
  end

  muldiv_iter_core u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_s),
    .step     (step_s),
    .mode_div (funct3_r[2]),
    .op_a     (mag_a_s),
    .op_b     (mag_b_s),
    .acc_next (acc_next_s)
  );

  // Sign fix-up on the value produced by the final iteration
  always_comb begin
    prod_s = (neg_a_r ^ neg_b_r) ? neg64(acc_next_s) : acc_next_s;
    quo_s  = (neg_a_r ^ neg_b_r) ? neg32(acc_next_s[31:0]) : acc_next_s[31:0];
    rem_s  = neg_a_r ? neg32(acc_next_s[63:32]) : acc_next_s[63:32];
    case (funct3_r)
      F3_MUL:                       final_res_s = prod_s[31:0];
      F3_MULH, F3_MULHSU, F3_MULHU: final_res_s = prod_s[63:32];
      F3_DIV, F3_DIVU:              final_res_s = quo_s;
      default:                      final_res_s = rem_s;
    endcase
  end

  // Next-state and datapath control
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    load_s      = 1'b0;
    step_s      = 1'b0;
    fin_s       = 1'b0;
    spec_s      = 1'b0;
    if (flush) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (start && special_s) begin
            state_nxt_s = DONE;
            spec_s      = 1'b1;
          end else if (start) begin
            state_nxt_s = CALC;
            cnt_nxt_s   = 6'd0;
            load_s      = 1'b1;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        CALC: begin
          step_s    = 1'b1;
          cnt_nxt_s = cnt_r + 6'd1;
          if (cnt_r == ITER_CNT - 6'd1) begin
            state_nxt_s = DONE;
            fin_s       = 1'b1;
          end else begin
            state_nxt_s = CALC;
          end
        end
        DONE:    state_nxt_s = IDLE;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // State, capture and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      cnt_r    <= 6'd0;
      funct3_r <= 3'd0;
      rd_r     <= 5'd0;
      neg_a_r  <= 1'b0;
      neg_b_r  <= 1'b0;
      result_r <= 32'd0;
      rd_out_r <= 5'd0;
      done_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      done_r  <= fin_s | spec_s;
      if (load_s) begin
        funct3_r <= funct3;
        rd_r     <= rd_addr;
        neg_a_r  <= neg_a_s;
        neg_b_r  <= neg_b_s;
      end
      if (fin_s) begin
        result_r <= final_res_s;
        rd_out_r <= rd_r;
      end else if (spec_s) begin
        result_r <= special_res_s;
        rd_out_r <= rd_addr;
      end
    end
  end

  assign busy   = rst_n & (((state_r == IDLE) & start & ~flush) | (state_r == CALC));
  assign done   = done_r;
  assign result = result_r;
  assign rd_out = rd_out_r;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed self-checking bench for ex_muldiv: results, latency, busy length,
// special cases, flush and mid-operation reset.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst_n, start, flush;
  logic [2:0]  funct3;
  logic [31:0] rs1_val, rs2_val, result;
  logic [4:0]  rd_addr, rd_out;
  logic        busy, done;

  int errors = 0;
  int checks = 0;
  logic [31:0] last_res = 32'd0;
  logic [4:0]  last_rd  = 5'd0;

`ifdef MULDIV_FAST_MUL_EN
  localparam int LAT_MUL = 1;
`else
  localparam int LAT_MUL = 33;
`endif

  always #5 clk = ~clk;

  ex_muldiv #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_addr(rd_addr), .flush(flush),
    .busy(busy), .done(done), .result(result), .rd_out(rd_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    funct3 = f3; rs1_val = a; rs2_val = b; rd_addr = rd; start = 1'b1;
  endtask

  // Called just after a negedge with start already high; lat counts edges
  // from the one that samples start up to the one that raises done.
  task automatic finish_op(input string tag, input logic [31:0] exp_res,
                           input logic [4:0] exp_rd, input int lat);
    int   cyc = 0;
    int   bcnt;
    logic seen = 1'b0;
    #1;
    bcnt = busy ? 1 : 0;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (done) seen = 1'b1;
      else if (busy) bcnt++;
    end
    check({tag, "_done"}, 32'(seen), 32'd1);
    check({tag, "_lat"}, 32'(cyc), 32'(lat));
    check({tag, "_busycnt"}, 32'(bcnt), 32'(lat));
    check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
    check({tag, "_result"}, result, exp_res);
    check({tag, "_rd"}, 32'(rd_out), 32'(exp_rd));
    last_res = exp_res;
    last_rd  = exp_rd;
    start = 1'b0;
    @(negedge clk);
    check({tag, "_done_single"}, 32'(done), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b1; flush = 1'b0;
    funct3 = 3'b000; rs1_val = 32'd3; rs2_val = 32'd4; rd_addr = 5'd7;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_rd", 32'(rd_out), 32'd0);
    start = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    issue(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd1);        finish_op("mul", 32'hFFFF_FFEB, 5'd1, LAT_MUL);
    issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2); finish_op("mulhu", 32'hFFFF_FFFE, 5'd2, LAT_MUL);
    issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3); finish_op("mulh", 32'h0000_0000, 5'd3, LAT_MUL);
    issue(3'b010, 32'hFFFF_FFFF, 32'd2, 5'd4);         finish_op("mulhsu", 32'hFFFF_FFFF, 5'd4, LAT_MUL);
    issue(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd5);         finish_op("div", 32'hFFFF_FFFD, 5'd5, 33);
    issue(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd6);         finish_op("rem", 32'hFFFF_FFFF, 5'd6, 33);
    issue(3'b101, 32'd100, 32'd7, 5'd7);               finish_op("divu", 32'd14, 5'd7, 33);
    issue(3'b111, 32'd100, 32'd7, 5'd8);               finish_op("remu", 32'd2, 5'd8, 33);
    issue(3'b101, 32'hFFFF_FFFF, 32'h10, 5'd9);        finish_op("divu_big", 32'h0FFF_FFFF, 5'd9, 33);
    issue(3'b111, 32'hFFFF_FFFF, 32'h10, 5'd10);       finish_op("remu_big", 32'h0000_000F, 5'd10, 33);
    issue(3'b101, 32'd5, 32'd0, 5'd11);                finish_op("divu_z", 32'hFFFF_FFFF, 5'd11, 1);
    issue(3'b110, 32'd5, 32'd0, 5'd12);                finish_op("rem_z", 32'd5, 5'd12, 1);
    issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13); finish_op("div_ovf", 32'h8000_0000, 5'd13, 1);
    issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14); finish_op("rem_ovf", 32'd0, 5'd14, 1);

    // Flush during the 10th CALC cycle
    issue(3'b101, 32'd100, 32'd7, 5'd20);
    repeat (10) @(negedge clk);
    check("flush_busy_calc", 32'(busy), 32'd1);
    flush = 1'b1; start = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    check("flush_done", 32'(done), 32'd0);
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_result", result, last_res);
    check("flush_rd", 32'(rd_out), 32'(last_rd));
    issue(3'b000, 32'd3, 32'd5, 5'd21);                finish_op("mul_after_flush", 32'd15, 5'd21, LAT_MUL);

    // Reset for one cycle mid-CALC with start held high
    issue(3'b101, 32'd100, 32'd7, 5'd22);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_rd", 32'(rd_out), 32'd0);
    rst_n = 1'b1;
    finish_op("after_rst", 32'd14, 5'd22, 33);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
